pixel_palette_mapper: RTL and testbench

- Streaming colour stage between the DDR port-1 read path and the HDMI controller input.
- Converts each 32-bit Mandelbrot point word (escape flag plus iteration count) into a 24-bit RGB pixel.
- Colour scheme is selected by the debounced resolution switches and changes only on frame boundaries.
- Three-stage pipeline with valid/ready handshakes on both sides, plus pixel/frame counters for status LEDs.

---
 rtl/pixel_palette_mapper_pkg.sv | 21 ++
 rtl/pixel_palette_mapper_palette_rom.sv | 36 +++
 rtl/pixel_palette_mapper.sv | 181 ++++++++++++++++++
 tb/tb_pixel_palette_mapper.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_palette_mapper_pkg.sv
// Shared definitions for the pixel palette mapper.
//   mode_t        : 4-bit palette mode as sampled from the resolution switches
//   MODE_*        : recognised palette modes; any other value renders as grayscale
//   RED/GRN/BLU_LSB : bit offsets of each 8-bit channel within the 24-bit RGB word
//   FRAME_PIXELS_DEFAULT : pixels in one 1920x1080 frame
package pixel_palette_mapper_pkg;

    typedef logic [3:0] mode_t;

    localparam mode_t MODE_GRAY = 4'd0;
    localparam mode_t MODE_BAND = 4'd1;
    localparam mode_t MODE_RAMP = 4'd2;
    localparam mode_t MODE_INV  = 4'd3;

    localparam int unsigned RED_LSB = 16;
    localparam int unsigned GRN_LSB = 8;
    localparam int unsigned BLU_LSB = 0;

    localparam int unsigned FRAME_PIXELS_DEFAULT = 1920 * 1080;

endpackage

// File: rtl/pixel_palette_mapper_palette_rom.sv
// Banded-palette lookup: fixed 16-entry rainbow, one-cycle registered read.
//   clk  : colour-domain clock
//   en   : read enable; data holds when low so it stays aligned with a stalled pipeline
//   addr : palette index
//   data : {red,green,blue} of the addressed entry, valid the cycle after en
module pixel_palette_mapper_palette_rom (
    input  logic        clk,
    input  logic        en,
    input  logic [3:0]  addr,
    output logic [23:0] data
);

    always_ff @(posedge clk) begin
        if (en) begin
            unique case (addr)
                4'd0:  data <= 24'hFF0000;
                4'd1:  data <= 24'hFF4000;
                4'd2:  data <= 24'hFF8000;
                4'd3:  data <= 24'hFFC000;
                4'd4:  data <= 24'hFFFF00;
                4'd5:  data <= 24'hC0FF00;
                4'd6:  data <= 24'h80FF00;
                4'd7:  data <= 24'h00FF00;
                4'd8:  data <= 24'h00FF80;
                4'd9:  data <= 24'h00FFFF;
                4'd10: data <= 24'h0080FF;
                4'd11: data <= 24'h0000FF;
                4'd12: data <= 24'h2000FF;
                4'd13: data <= 24'h4000FF;
                4'd14: data <= 24'h6000FF;
                4'd15: data <= 24'h8000FF;
            endcase
        end
    end

endmodule

// File: rtl/pixel_palette_mapper.sv
// Colour stage between the DDR read path and the HDMI controller: maps each
// Mandelbrot point word (escape flag + iteration count) to a 24-bit RGB pixel.
// Three-stage pipeline, all stages advance together whenever the output register
// is empty or being consumed.
//   clk, reset            : colour-domain clock, synchronous active-high reset
//   mode_sel, update      : palette request; update pulse samples it into the pending mode
//   in_data/last/valid/ready  : upstream point stream, in_last marks end of frame
//   out_rgb/last/valid/ready  : downstream pixel stream
//   frame_count           : completed frames leaving the block (wraps)
//   length_error          : sticky, a frame was not exactly FRAME_PIXELS words long
module pixel_palette_mapper
    import pixel_palette_mapper_pkg::*;
#(
    parameter int unsigned ITER_W         = 16,
    parameter int unsigned PAL_DEPTH_LOG2 = 4,
    parameter int unsigned FRAME_PIXELS   = FRAME_PIXELS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mode_sel,
    input  logic        update,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] out_rgb,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  frame_count,
    output logic        length_error
);

    localparam int unsigned CNT_W = $clog2(FRAME_PIXELS + 1);
    localparam logic [CNT_W:0] FRAME_LEN = (CNT_W + 1)'(FRAME_PIXELS);

    logic adv, accept;

    // S1
    logic              s1_valid_q, s1_esc_q, s1_last_q;
    logic [ITER_W-1:0] s1_iter_q;
    mode_t             s1_mode_q;
    // S2 (palette data comes from the ROM register alongside)
    logic              s2_valid_q, s2_esc_q, s2_last_q;
    logic [ITER_W-1:0] s2_iter_q;
    mode_t             s2_mode_q;
    logic [23:0]       lut_rgb;
    // S3 / output
    logic              out_valid_q, out_last_q;
    logic [23:0]       out_rgb_q, rgb_s3;

    mode_t             pending_q, pending_d, active_q, active_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [CNT_W:0]    cnt_inc;
    logic              length_error_q, length_error_d;
    logic [7:0]        frame_count_q;

    logic [ITER_W-1:0] quarter;
    logic [7:0]        iter8, ramp_g;
    logic              unused_in_bits;

    assign unused_in_bits = ^in_data[30:ITER_W];

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv && !reset;
    assign accept   = in_valid && in_ready;

    // A new mode takes effect on the word after the frame's last word, so a whole
    // frame is always rendered in one scheme.
    always_comb begin
        pending_d = pending_q;
        active_d  = active_q;
        if (update) begin
            pending_d = mode_sel;
        end
        if (accept && in_last) begin
            active_d = update ? mode_sel : pending_q;
        end
    end

    always_comb begin
        cnt_inc        = {1'b0, pix_cnt_q} + (CNT_W + 1)'(1);
        pix_cnt_d      = pix_cnt_q;
        length_error_d = length_error_q;
        if (accept) begin
            if (in_last) begin
                if (cnt_inc != FRAME_LEN) begin
                    length_error_d = 1'b1;
                end
                pix_cnt_d = '0;
            end else begin
                // A full frame's worth of words without in_last is already too long.
                if (cnt_inc >= FRAME_LEN) begin
                    length_error_d = 1'b1;
                end
                if (!(&pix_cnt_q)) begin
                    pix_cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
        end
    end

    always_comb begin
        iter8   = s2_iter_q[7:0];
        quarter = s2_iter_q >> 2;
        ramp_g  = (|quarter[ITER_W-1:8]) ? 8'hFF : quarter[7:0];
        rgb_s3  = '0;
        if (s2_valid_q && s2_esc_q) begin
            case (s2_mode_q)
                MODE_BAND: rgb_s3 = lut_rgb;
                MODE_RAMP: begin
                    rgb_s3[RED_LSB +: 8] = iter8;
                    rgb_s3[GRN_LSB +: 8] = ramp_g;
                    rgb_s3[BLU_LSB +: 8] = 8'hFF - iter8;
                end
                MODE_INV: rgb_s3 = {3{~iter8}};
                default:  rgb_s3 = {3{iter8}};  // MODE_GRAY and unassigned modes
            endcase
        end
    end

    pixel_palette_mapper_palette_rom u_palette_rom (
        .clk  (clk),
        .en   (adv),
        .addr (s1_iter_q[PAL_DEPTH_LOG2-1:0]),
        .data (lut_rgb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q     <= 1'b0;
            s1_esc_q       <= 1'b0;
            s1_last_q      <= 1'b0;
            s1_iter_q      <= '0;
            s1_mode_q      <= MODE_GRAY;
            s2_valid_q     <= 1'b0;
            s2_esc_q       <= 1'b0;
            s2_last_q      <= 1'b0;
            s2_iter_q      <= '0;
            s2_mode_q      <= MODE_GRAY;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_rgb_q      <= '0;
            pending_q      <= MODE_GRAY;
            active_q       <= MODE_GRAY;
            pix_cnt_q      <= '0;
            length_error_q <= 1'b0;
            frame_count_q  <= '0;
        end else begin
            if (adv) begin
                s1_valid_q  <= accept;
                s1_esc_q    <= in_data[31];
                s1_last_q   <= in_last;
                s1_iter_q   <= in_data[ITER_W-1:0];
                s1_mode_q   <= active_q;
                s2_valid_q  <= s1_valid_q;
                s2_esc_q    <= s1_esc_q;
                s2_last_q   <= s1_last_q;
                s2_iter_q   <= s1_iter_q;
                s2_mode_q   <= s1_mode_q;
                out_valid_q <= s2_valid_q;
                out_last_q  <= s2_valid_q && s2_last_q;
                out_rgb_q   <= rgb_s3;
            end
            pending_q      <= pending_d;
            active_q       <= active_d;
            pix_cnt_q      <= pix_cnt_d;
            length_error_q <= length_error_d;
            if (out_valid_q && out_ready && out_last_q) begin
                frame_count_q <= frame_count_q + 8'd1;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign out_rgb      = out_rgb_q;
    assign frame_count  = frame_count_q;
    assign length_error = length_error_q;

endmodule

// File: tb/tb_pixel_palette_mapper.sv
// Directed bench for pixel_palette_mapper with an 8-pixel frame.
module tb_pixel_palette_mapper;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mode_sel;
    logic        update;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] out_rgb;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  frame_count;
    logic        length_error;

    pixel_palette_mapper #(
        .ITER_W         (16),
        .PAL_DEPTH_LOG2 (4),
        .FRAME_PIXELS   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mode_sel     (mode_sel),
        .update       (update),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_rgb      (out_rgb),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .frame_count  (frame_count),
        .length_error (length_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Stimulus table: word, last flag, update pulse with mode_sel, expected {last,rgb}.
    logic [31:0] vec_data[$];
    logic        vec_last[$];
    logic        vec_upd[$];
    logic [3:0]  vec_sel[$];
    logic [24:0] vec_exp[$];

    task automatic add(input logic [31:0] d, input logic l, input logic u, input logic [3:0] s,
                       input logic [23:0] rgb);
        vec_data.push_back(d);
        vec_last.push_back(l);
        vec_upd.push_back(u);
        vec_sel.push_back(s);
        vec_exp.push_back({l, rgb});
    endtask

    // Present one word (inputs change 1 time unit after a rising edge) and hold it until taken.
    task automatic send(input int idx);
        int guard;
        in_data  = vec_data[idx];
        in_last  = vec_last[idx];
        update   = vec_upd[idx];
        mode_sel = vec_sel[idx];
        in_valid = 1'b1;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) check_eq("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        update   = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Handshakes are observed mid-cycle, where every signal is settled for the next edge.
    logic [24:0] out_q[$];
    int          out_cyc[$];
    int          acc_cyc[$];
    logic        stalled = 1'b0;
    logic [24:0] stall_val;

    always @(negedge clk) begin
        if (!reset) begin
            if (in_valid && in_ready) acc_cyc.push_back(cyc);
            if (out_valid && out_ready) begin
                out_q.push_back({out_last, out_rgb});
                out_cyc.push_back(cyc);
            end
            if (stalled) check_eq("stall_hold", {6'd0, out_valid, out_last, out_rgb},
                                  {6'd0, 1'b1, stall_val});
            if (out_valid && !out_ready) begin
                check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
                stalled   <= 1'b1;
                stall_val <= {out_last, out_rgb};
            end else begin
                stalled <= 1'b0;
            end
        end else begin
            stalled <= 1'b0;
        end
    end

    int n_exp;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        update    = 1'b0;
        mode_sel  = '0;
        out_ready = 1'b1;

        // Frame A, grayscale
        add(32'h8000_0010, 0, 0, 0, 24'h101010);
        add(32'h8000_0020, 0, 0, 0, 24'h202020);
        add(32'h8000_0030, 0, 0, 0, 24'h303030);
        add(32'h8000_0040, 0, 0, 0, 24'h404040);
        add(32'h0000_00FF, 0, 0, 0, 24'h000000);
        add(32'h8000_0050, 0, 0, 0, 24'h505050);
        add(32'h8000_0060, 0, 0, 0, 24'h606060);
        add(32'h8000_0070, 1, 0, 0, 24'h707070);
        // Frame B, grayscale; banded requested mid-frame
        add(32'h8000_001F, 0, 0, 0, 24'h1F1F1F);
        add(32'h8000_0002, 0, 1, 1, 24'h020202);
        add(32'h8000_0011, 0, 0, 0, 24'h111111);
        add(32'h8000_0022, 0, 0, 0, 24'h222222);
        add(32'h8000_0033, 0, 0, 0, 24'h333333);
        add(32'h8000_0044, 0, 0, 0, 24'h444444);
        add(32'h0000_0005, 0, 0, 0, 24'h000000);
        add(32'h8000_0003, 1, 0, 0, 24'h030303);
        // Frame C, banded; ramp requested together with the last word
        add(32'h8000_001F, 0, 0, 0, 24'h8000FF);
        add(32'h8000_0000, 0, 0, 0, 24'hFF0000);
        add(32'h0000_00FF, 0, 0, 0, 24'h000000);
        add(32'h8000_0007, 0, 0, 0, 24'h00FF00);
        add(32'h8000_0010, 0, 0, 0, 24'hFF0000);
        add(32'h8000_000B, 0, 0, 0, 24'h0000FF);
        add(32'h8000_0004, 0, 0, 0, 24'hFFFF00);
        add(32'h8000_002F, 1, 1, 2, 24'h8000FF);
        // Frame D, ramp; inverted requested mid-frame
        add(32'h8000_0040, 0, 0, 0, 24'h4010BF);
        add(32'h8000_0500, 0, 0, 0, 24'h00FFFF);
        add(32'h8000_0404, 0, 0, 0, 24'h04FFFB);
        add(32'h8000_0000, 0, 1, 3, 24'h0000FF);
        add(32'h8000_03FC, 0, 0, 0, 24'hFCFF03);
        add(32'h0000_0040, 0, 0, 0, 24'h000000);
        add(32'h8000_0080, 0, 0, 0, 24'h80207F);
        add(32'h8000_0008, 1, 0, 0, 24'h0802F7);
        // Frame E, inverted, only 6 words; unassigned mode 9 requested
        add(32'h8000_0010, 0, 1, 9, 24'hEFEFEF);
        add(32'h8000_0000, 0, 0, 0, 24'hFFFFFF);
        add(32'h0000_00AA, 0, 0, 0, 24'h000000);
        add(32'h8000_00F0, 0, 0, 0, 24'h0F0F0F);
        add(32'h8000_0155, 0, 0, 0, 24'hAAAAAA);
        add(32'h8000_0001, 1, 0, 0, 24'hFEFEFE);
        // Frame F, mode 9 renders as grayscale; banded requested with its last word
        add(32'h8000_0033, 1, 1, 1, 24'h333333);
        n_exp = vec_exp.size();
        // Mid-frame words flushed by reset, then one word that must use the reset mode
        add(32'h8000_0011, 0, 0, 0, 24'h000000);
        add(32'h8000_0012, 0, 0, 0, 24'h000000);
        add(32'h8000_0021, 1, 0, 0, 24'h212121);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_rgb", {8'd0, out_rgb}, 32'd0);
        check_eq("rst_out_last", {31'd0, out_last}, 32'd0);
        check_eq("rst_frame_count", {24'd0, frame_count}, 32'd0);
        check_eq("rst_length_error", {31'd0, length_error}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) send(i);
        drain();
        check_eq("frame_count_A", {24'd0, frame_count}, 32'd1);
        check_eq("length_error_A", {31'd0, length_error}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i < out_cyc.size() && i < acc_cyc.size())
                check_eq($sformatf("latency_%0d", i), out_cyc[i] - acc_cyc[i], 32'd3);
            else
                check_eq($sformatf("latency_%0d_missing", i), out_cyc.size(), 32'd4);
        end

        fork
            for (int i = 8; i < 16; i++) send(i);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        for (int i = 16; i < 32; i++) send(i);
        drain();
        check_eq("frame_count_D", {24'd0, frame_count}, 32'd4);
        check_eq("length_error_D", {31'd0, length_error}, 32'd0);
        for (int i = 32; i < 38; i++) send(i);
        drain();
        check_eq("frame_count_E", {24'd0, frame_count}, 32'd5);
        check_eq("length_error_E", {31'd0, length_error}, 32'd1);
        send(38);
        drain();
        check_eq("frame_count_F", {24'd0, frame_count}, 32'd6);

        check_eq("pixel_count", out_q.size(), n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (i < out_q.size())
                check_eq($sformatf("pixel_%0d", i), {7'd0, out_q[i]}, {7'd0, vec_exp[i]});
        end

        // Reset with words still in the pipe
        out_ready = 1'b0;
        send(n_exp);
        send(n_exp + 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("pipe_held", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("midrst_frame_count", {24'd0, frame_count}, 32'd0);
        check_eq("midrst_length_error", {31'd0, length_error}, 32'd0);
        check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        drain();
        check_eq("no_partial_pixel", out_q.size(), n_exp);
        send(n_exp + 2);
        drain();
        check_eq("post_rst_count", out_q.size(), n_exp + 1);
        if (out_q.size() == n_exp + 1)
            check_eq("post_rst_mode", {7'd0, out_q[n_exp]}, {7'd0, vec_exp[n_exp + 2]});
        check_eq("post_rst_frame_count", {24'd0, frame_count}, 32'd1);
        check_eq("post_rst_length_error", {31'd0, length_error}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
